// File: rtl/cell_collector.sv
// ---------------------------------------------------------------------------
// cell_collector
//   Cell-to-router injection path. Sixteen processing cells present
//   bit-serial messages. Seven independent channel FSMs each pick one
//   requesting cell round-robin and stream a fixed-length message onto the
//   router channel, tagging every bit with the 4-bit source-cell address.
//
// Optional feature (compile-time macro COLLECT_PARITY_EN):
//   when defined, each message is followed by one even-parity bit, the XOR
//   of the MSG_LEN data bits. The cell is not advanced for that bit.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   cellReq      [15:0] cell i has a message ready
//   cellDim      [47:0] cellDim[3i+2:3i] target channel of cell i (7 = none)
//   cellBit      [15:0] current serial data bit of each cell
//   cellGrant    [15:0] registered one-cycle pulse, cell i won a channel
//   cellAdv      [15:0] cell i's bit was consumed this cycle (combinational)
//   chanReady    [6:0]  downstream buffer c accepts a bit
//   chanValid    [6:0]  channel c presents a bit (combinational from state)
//   chanBit      [6:0]  serial data bit on channel c
//   chanSrc      [27:0] chanSrc[4c+3:4c] source cell on channel c
// ---------------------------------------------------------------------------
module cell_collector #(
   parameter int unsigned MSG_LEN = 32,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cellReq,
   input  logic [47:0] cellDim,
   input  logic [15:0] cellBit,
   output logic [15:0] cellGrant,
   output logic [15:0] cellAdv,
   input  logic [6:0]  chanReady,
   output logic [6:0]  chanValid,
   output logic [6:0]  chanBit,
   output logic [27:0] chanSrc
);

   localparam int unsigned NCELL = 16;
   localparam int unsigned NCHAN = 7;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GRANT  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

`ifdef COLLECT_PARITY_EN
   // Count MSG_LEN is the parity slot.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_LEN);
`else
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_LEN - 1);
`endif

   logic [1:0]       state_q [NCHAN];
   logic [1:0]       state_d [NCHAN];
   logic [3:0]       src_q   [NCHAN];
   logic [3:0]       src_d   [NCHAN];
   logic [CNT_W-1:0] cnt_q   [NCHAN];
   logic [CNT_W-1:0] cnt_d   [NCHAN];
   logic [3:0]       ptr_q   [NCHAN];
   logic [3:0]       ptr_d   [NCHAN];
`ifdef COLLECT_PARITY_EN
   logic             par_q   [NCHAN];
   logic             par_d   [NCHAN];
`endif
   logic [15:0]      grant_d;

   // State registers for all channels plus the registered grant pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCHAN; c++) begin
            state_q[c] <= S_IDLE;
            src_q[c]   <= '0;
            cnt_q[c]   <= '0;
            ptr_q[c]   <= '0;
`ifdef COLLECT_PARITY_EN
            par_q[c]   <= 1'b0;
`endif
         end
         cellGrant <= '0;
      end else begin
         for (int c = 0; c < NCHAN; c++) begin
            state_q[c] <= state_d[c];
            src_q[c]   <= src_d[c];
            cnt_q[c]   <= cnt_d[c];
            ptr_q[c]   <= ptr_d[c];
`ifdef COLLECT_PARITY_EN
            par_q[c]   <= par_d[c];
`endif
         end
         cellGrant <= grant_d;
      end
   end

   // Per-channel arbitration, next state and channel/cell outputs.
   always_comb begin
      logic       found;
      logic [3:0] win;
      logic [3:0] idx;
      logic       dbit;

      grant_d   = '0;
      cellAdv   = '0;
      chanValid = '0;
      chanBit   = '0;
      chanSrc   = '0;
      found     = 1'b0;
      win       = '0;
      idx       = '0;
      dbit      = 1'b0;

      for (int c = 0; c < NCHAN; c++) begin
         state_d[c] = state_q[c];
         src_d[c]   = src_q[c];
         cnt_d[c]   = cnt_q[c];
         ptr_d[c]   = ptr_q[c];
`ifdef COLLECT_PARITY_EN
         par_d[c]   = par_q[c];
`endif

         // First eligible cell at or after the pointer; 4-bit add wraps mod 16.
         found = 1'b0;
         win   = '0;
         for (int k = 0; k < NCELL; k++) begin
            idx = ptr_q[c] + 4'(k);
            if (!found && cellReq[idx] && (cellDim[3*idx +: 3] == 3'(c))) begin
               found = 1'b1;
               win   = idx;
            end
         end

         case (state_q[c])
            S_IDLE: begin
               if (found) begin
                  state_d[c]   = S_GRANT;
                  src_d[c]     = win;
                  ptr_d[c]     = win + 4'd1;
                  cnt_d[c]     = '0;
`ifdef COLLECT_PARITY_EN
                  par_d[c]     = 1'b0;
`endif
                  grant_d[win] = 1'b1;
               end
            end
            S_GRANT: state_d[c] = S_STREAM;
            S_STREAM: begin
               dbit = cellBit[src_q[c]];
`ifdef COLLECT_PARITY_EN
               if (cnt_q[c] == LAST) dbit = par_q[c];
`endif
               chanValid[c]        = 1'b1;
               chanBit[c]          = dbit;
               chanSrc[4*c +: 4]   = src_q[c];
               if (chanReady[c]) begin
                  cnt_d[c] = cnt_q[c] + CNT_W'(1);
`ifdef COLLECT_PARITY_EN
                  // Parity slot does not consume a cell bit.
                  if (cnt_q[c] != LAST) begin
                     cellAdv[src_q[c]] = 1'b1;
                     par_d[c]          = par_q[c] ^ dbit;
                  end
`else
                  cellAdv[src_q[c]] = 1'b1;
`endif
                  if (cnt_q[c] == LAST) state_d[c] = S_IDLE;
               end
            end
            default: state_d[c] = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_collector.sv
// ---------------------------------------------------------------------------
// tb_cell_collector
//   Directed bench for cell_collector. Cells are modelled as 32-bit patterns
//   shifted out MSB-first, advanced by cellAdv and restarted by cellGrant.
//   A monitor counts grants, advances and transfers and captures channel bits.
//   Also builds with COLLECT_PARITY_EN defined (one extra parity bit).
// ---------------------------------------------------------------------------
module tb_cell_collector;

`ifdef COLLECT_PARITY_EN
   localparam int NB = 33;
`else
   localparam int NB = 32;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] cellReq;
   logic [47:0] cellDim;
   logic [15:0] cellBit;
   logic [15:0] cellGrant;
   logic [15:0] cellAdv;
   logic [6:0]  chanReady;
   logic [6:0]  chanValid;
   logic [6:0]  chanBit;
   logic [27:0] chanSrc;

   bit [31:0] pat    [16];
   int        pos    [16];
   int        advs   [16];
   int        grants [16];
   int        xfers  [7];
   bit [63:0] cap    [7];
   int        gq     [$];

   int n_vec = 0;
   int n_bad = 0;

   cell_collector #(.MSG_LEN(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cellReq   (cellReq),
      .cellDim   (cellDim),
      .cellBit   (cellBit),
      .cellGrant (cellGrant),
      .cellAdv   (cellAdv),
      .chanReady (chanReady),
      .chanValid (chanValid),
      .chanBit   (chanBit),
      .chanSrc   (chanSrc)
   );

   always #5 clk = ~clk;

   // Cell model: present pattern bit at current position, MSB first.
   always_comb begin
      for (int i = 0; i < 16; i++)
         cellBit[i] = (pos[i] < 32) ? pat[i][31 - pos[i]] : 1'b0;
   end

   // Monitor: counts and captures on the active edge.
   always @(posedge clk) begin
      for (int c = 0; c < 7; c++) begin
         if (chanValid[c] && chanReady[c]) begin
            cap[c]   <= {cap[c][62:0], chanBit[c]};
            xfers[c] <= xfers[c] + 1;
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (cellAdv[i]) advs[i] <= advs[i] + 1;
         if (cellGrant[i]) begin
            grants[i] <= grants[i] + 1;
            gq.push_back(i);
            pos[i] <= 0;
         end else if (cellAdv[i]) begin
            pos[i] <= pos[i] + 1;
         end
      end
   end

   function automatic bit [31:0] data_of(input bit [63:0] v);
`ifdef COLLECT_PARITY_EN
      return v[32:1];
`else
      return v[31:0];
`endif
   endfunction

   task automatic set_dim(input int i, input logic [2:0] d);
      cellDim[3*i +: 3] = d;
   endtask

   task automatic test_reset();
      cellReq   = '0;
      cellDim   = '1;
      chanReady = '1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({cellGrant, cellAdv, chanValid, chanBit, chanSrc} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %0h want 0", {cellGrant, cellAdv, chanValid, chanBit, chanSrc});
      end
      rst_n = 1'b1;
      pat[3] = 32'hDEAD_BEEF;
      set_dim(3, 3'd2);
      cellReq[3] = 1'b1;
      @(negedge clk);
      cellReq[3] = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (chanValid[2] !== 1'b1 || chanSrc[11:8] !== 4'd3) begin
         n_bad++;
         $display("FAIL reset_prestream: got valid=%b src=%0h want valid=1 src=3", chanValid[2], chanSrc[11:8]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({cellGrant, cellAdv, chanValid, chanBit, chanSrc} !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got %0h want 0", {cellGrant, cellAdv, chanValid, chanBit, chanSrc});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (chanValid !== 7'h00) begin
         n_bad++;
         $display("FAIL reset_idle_after: got chanValid=%0h want 0", chanValid);
      end
      // Pointer back at 0: cell 1 must beat cell 4 (pre-reset pointer was 4).
      set_dim(1, 3'd2);
      set_dim(4, 3'd2);
      cellReq[1] = 1'b1;
      cellReq[4] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h0002) begin
         n_bad++;
         $display("FAIL reset_ptr: got cellGrant=%0h want 0002", cellGrant);
      end
      cellReq = '0;
      repeat (NB + 2) @(negedge clk);
   endtask

   task automatic test_single();
      int a0, x0, g0, bad;
      pat[5] = 32'hA5C3_0F1E;
      set_dim(5, 3'd3);
      a0 = advs[5]; x0 = xfers[3]; g0 = grants[5];
      cellReq[5] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h0020 || chanValid[3] !== 1'b0) begin
         n_bad++;
         $display("FAIL single_grant: got grant=%0h valid=%b want 0020/0", cellGrant, chanValid[3]);
      end
      cellReq[5] = 1'b0;
      bad = 0;
      for (int k = 0; k < NB; k++) begin
         @(negedge clk);
         if (chanValid[3] !== 1'b1 || chanSrc[15:12] !== 4'd5 || cellGrant !== 16'h0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL single_stream: got %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      n_vec++;
      if (chanValid[3] !== 1'b0) begin
         n_bad++;
         $display("FAIL single_end: got valid=%b want 0", chanValid[3]);
      end
      n_vec++;
      if (data_of(cap[3]) !== 32'hA5C3_0F1E) begin
         n_bad++;
         $display("FAIL single_data: got %0h want a5c30f1e", data_of(cap[3]));
      end
      n_vec++;
      if (advs[5] - a0 !== 32 || xfers[3] - x0 !== NB || grants[5] - g0 !== 1) begin
         n_bad++;
         $display("FAIL single_counts: got adv=%0d xfer=%0d grant=%0d want 32/%0d/1",
                  advs[5] - a0, xfers[3] - x0, grants[5] - g0, NB);
      end
   endtask

   task automatic test_round_robin();
      int q0, cyc;
      int exp_rr[4] = '{2, 9, 14, 2};
      int exp_wr[2] = '{15, 0};
      pat[2] = 32'h1111_0000; pat[9] = 32'h2222_0000; pat[14] = 32'h3333_0000;
      set_dim(2, 3'd0); set_dim(9, 3'd0); set_dim(14, 3'd0);
      q0 = gq.size();
      cellReq[2] = 1'b1; cellReq[9] = 1'b1; cellReq[14] = 1'b1;
      cyc = 0;
      while (gq.size() - q0 < 4 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      cellReq = '0;
      n_vec++;
      if (gq.size() - q0 < 4) begin
         n_bad++;
         $display("FAIL rr_timeout: got %0d grants want 4", gq.size() - q0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (gq[q0 + k] !== exp_rr[k]) begin
               n_bad++;
               $display("FAIL rr_order%0d: got cell %0d want %0d", k, gq[q0 + k], exp_rr[k]);
            end
         end
      end
      repeat (NB + 2) @(negedge clk);
      // Drive pointer to 15 by granting cell 14 alone.
      cellReq[14] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h4000) begin
         n_bad++;
         $display("FAIL rr_ptr15: got cellGrant=%0h want 4000", cellGrant);
      end
      cellReq = '0;
      repeat (NB + 2) @(negedge clk);
      set_dim(0, 3'd0); set_dim(15, 3'd0);
      q0 = gq.size();
      cellReq[0] = 1'b1; cellReq[15] = 1'b1;
      cyc = 0;
      while (gq.size() - q0 < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      cellReq = '0;
      n_vec++;
      if (gq.size() - q0 < 2) begin
         n_bad++;
         $display("FAIL rr_wrap_timeout: got %0d grants want 2", gq.size() - q0);
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (gq[q0 + k] !== exp_wr[k]) begin
               n_bad++;
               $display("FAIL rr_wrap%0d: got cell %0d want %0d", k, gq[q0 + k], exp_wr[k]);
            end
         end
      end
      repeat (NB + 2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int a0, x0, len, bad;
      pat[6] = 32'h1A34_5678;
      set_dim(6, 3'd1);
      a0 = advs[6]; x0 = xfers[1];
      cellReq[6] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h0040) begin
         n_bad++;
         $display("FAIL bp_grant: got cellGrant=%0h want 0040", cellGrant);
      end
      cellReq[6] = 1'b0;
      len = 0; bad = 0;
      for (int k = 0; k < NB + 20; k++) begin
         @(negedge clk);
         if (chanValid[1] !== 1'b1) break;
         len++;
         chanReady[1] = !(k >= 4 && k <= 9);
         #1;
         // Four bits consumed before the stall, so bit 27 is held.
         if (k >= 4 && k <= 9)
            if (chanBit[1] !== 1'b1 || chanSrc[7:4] !== 4'd6 || cellAdv[6] !== 1'b0) bad++;
      end
      chanReady = '1;
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL bp_stall: got %0d bad stall cycles want 0", bad);
      end
      n_vec++;
      if (len !== NB + 6) begin
         n_bad++;
         $display("FAIL bp_length: got %0d valid cycles want %0d", len, NB + 6);
      end
      n_vec++;
      if (xfers[1] - x0 !== NB || advs[6] - a0 !== 32 || data_of(cap[1]) !== 32'h1A34_5678) begin
         n_bad++;
         $display("FAIL bp_totals: got xfer=%0d adv=%0d data=%0h want %0d/32/1a345678",
                  xfers[1] - x0, advs[6] - a0, data_of(cap[1]), NB);
      end
   endtask

   task automatic test_concurrency();
      int g0 [8];
      int bad;
      for (int i = 0; i < 7; i++) begin
         set_dim(i, 3'(i));
         pat[i] = 32'h0F0F_0000 + 32'(i);
         cellReq[i] = 1'b1;
      end
      set_dim(7, 3'd7);
      cellReq[7] = 1'b1;
      for (int i = 0; i < 8; i++) g0[i] = grants[i];
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h007F) begin
         n_bad++;
         $display("FAIL conc_grant: got cellGrant=%0h want 007f", cellGrant);
      end
      cellReq[6:0] = '0;
      @(negedge clk);
      n_vec++;
      if (chanValid !== 7'h7F || chanSrc !== 28'h6543210) begin
         n_bad++;
         $display("FAIL conc_stream: got valid=%0h src=%0h want 7f/6543210", chanValid, chanSrc);
      end
      repeat (NB + 1) @(negedge clk);
      n_vec++;
      if (chanValid !== 7'h00 || grants[7] - g0[7] !== 0) begin
         n_bad++;
         $display("FAIL conc_invalid: got valid=%0h cell7 grants=%0d want 0/0", chanValid, grants[7] - g0[7]);
      end
      bad = 0;
      for (int i = 0; i < 7; i++) if (grants[i] - g0[i] != 1) bad++;
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL conc_counts: got %0d cells with wrong grant count want 0", bad);
      end
      cellReq[7] = 1'b0;
   endtask

   task automatic test_back_to_back();
      int a0, bad;
      pat[8] = 32'h0000_001F;
      pat[9] = 32'h0000_0000;
      set_dim(8, 3'd4); set_dim(9, 3'd4);
      a0 = advs[8];
      cellReq[8] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h0100) begin
         n_bad++;
         $display("FAIL b2b_grant: got cellGrant=%0h want 0100", cellGrant);
      end
      cellReq[8] = 1'b0;
      cellReq[9] = 1'b1;
      bad = 0;
      for (int k = 0; k < NB; k++) begin
         @(negedge clk);
         if (cellGrant[9] !== 1'b0 || chanValid[4] !== 1'b1 || chanSrc[19:16] !== 4'd8) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL b2b_hold: got %0d bad cycles want 0", bad);
      end
      @(negedge clk);
      n_vec++;
      if (chanValid[4] !== 1'b0 || cellGrant !== 16'h0) begin
         n_bad++;
         $display("FAIL b2b_gap: got valid=%b grant=%0h want 0/0", chanValid[4], cellGrant);
      end
      n_vec++;
      if (data_of(cap[4]) !== 32'h0000_001F || advs[8] - a0 !== 32) begin
         n_bad++;
         $display("FAIL b2b_data: got data=%0h adv=%0d want 1f/32", data_of(cap[4]), advs[8] - a0);
      end
`ifdef COLLECT_PARITY_EN
      n_vec++;
      if (cap[4][0] !== 1'b1) begin
         n_bad++;
         $display("FAIL parity_ones: got %b want 1", cap[4][0]);
      end
`endif
      @(negedge clk);
      n_vec++;
      if (cellGrant !== 16'h0200) begin
         n_bad++;
         $display("FAIL b2b_next: got cellGrant=%0h want 0200", cellGrant);
      end
      cellReq[9] = 1'b0;
      repeat (NB + 1) @(negedge clk);
      n_vec++;
      if (chanValid[4] !== 1'b0 || data_of(cap[4]) !== 32'h0) begin
         n_bad++;
         $display("FAIL b2b_zero: got valid=%b data=%0h want 0/0", chanValid[4], data_of(cap[4]));
      end
`ifdef COLLECT_PARITY_EN
      n_vec++;
      if (cap[4][0] !== 1'b0) begin
         n_bad++;
         $display("FAIL parity_zero: got %b want 0", cap[4][0]);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_concurrency();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
